// File: rtl/dru_pkg.sv
// Shared types and constants for the 4x-oversampling bit recovery stage.
package dru_pkg;

  localparam int NUM_PHASES = 4;
  localparam int PHASE_W    = $clog2(NUM_PHASES);
  localparam int MAX_BITS   = 2;
  localparam int BITS_W     = MAX_BITS + 1;
  localparam int NUM_BITS_W = $clog2(MAX_BITS + 1);

  // Phase error between an observed edge and the current sampling point.
  typedef enum logic [1:0] {
    CENTRED = 2'd0,
    LATE    = 2'd1,
    AMBIG   = 2'd2,
    EARLY   = 2'd3
  } phase_err_e;

  // The eye centre sits two samples after the edge; the modulo-4 distance
  // from the current phase to that centre is the error code.
  function automatic phase_err_e phase_error(input logic [PHASE_W-1:0] pos,
                                             input logic [PHASE_W-1:0] phase);
    logic [PHASE_W-1:0] d;
    d = pos + PHASE_W'(2) - phase;
    return phase_err_e'(d);
  endfunction

endpackage

// File: rtl/dru_phase_filter.sv
// Early/late integrator and lock counter for the bit recovery phase tracker.
module dru_phase_filter
  import dru_pkg::*;
#(
  parameter int FILT_THRESH = 4,
  parameter int LOCK_COUNT  = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       edge_valid,
  input  phase_err_e d,
  output logic       step_late,
  output logic       step_early,
  output logic       locked
);

  localparam int IW = $clog2(FILT_THRESH + 1) + 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic signed [IW-1:0] THR   = IW'(FILT_THRESH);
  localparam logic signed [IW-1:0] THR_N = -THR;
  localparam logic signed [IW:0]   THR_X = (IW+1)'(FILT_THRESH);

  logic signed [IW-1:0] integ;
  logic signed [IW-1:0] integ_next;
  logic [LW-1:0]        lock_cnt;

  // Step the integrator by one in either direction, clamped to +/-FILT_THRESH.
  function automatic logic signed [IW-1:0] sat_step(input logic signed [IW-1:0] a,
                                                    input logic up);
    logic signed [IW:0] ext;
    logic signed [IW:0] one;
    logic signed [IW:0] s;
    ext = {a[IW-1], a};
    one = (IW+1)'(1);
    s   = up ? (ext + one) : (ext - one);
    if (s > THR_X)       return THR;
    else if (s < -THR_X) return THR_N;
    else                 return s[IW-1:0];
  endfunction

  // Integrate late/early edges and flag a step when a threshold is reached.
  always_comb begin
    integ_next = integ;
    step_late  = 1'b0;
    step_early = 1'b0;
    if (edge_valid && d == LATE) begin
      integ_next = sat_step(integ, 1'b1);
      step_late  = (integ_next == THR);
    end else if (edge_valid && d == EARLY) begin
      integ_next = sat_step(integ, 1'b0);
      step_early = (integ_next == THR_N);
    end
  end

  // Integrator clears on a step; lock counts centred edges and drops on
  // any step or half-UI ambiguous edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      integ    <= '0;
      lock_cnt <= '0;
    end else begin
      integ <= (step_late || step_early) ? '0 : integ_next;
      if (step_late || step_early || (edge_valid && d == AMBIG))
        lock_cnt <= '0;
      else if (edge_valid && d == CENTRED && lock_cnt != LW'(LOCK_COUNT))
        lock_cnt <= lock_cnt + LW'(1);
    end
  end

  assign locked = (lock_cnt == LW'(LOCK_COUNT));

endmodule

// File: rtl/oversample_bit_recovery.sv
// 4x-oversampling data recovery: tracks the eye centre from edge positions
// and emits 0, 1 or 2 recovered bits per input word.
module oversample_bit_recovery
  import dru_pkg::*;
#(
  parameter int FILT_THRESH = 4,
  parameter int LOCK_COUNT  = 16,
  parameter int INIT_PHASE  = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_PHASES-1:0] in_samples,
  input  logic                  in_valid,
  output logic [BITS_W-1:0]     bits,
  output logic [NUM_BITS_W-1:0] num_bits,
  output logic                  locked,
  output logic [PHASE_W-1:0]    phase
);

  logic                  prev_sample;
  logic [NUM_PHASES:0]   w;
  logic [NUM_PHASES-1:0] e;
  logic                  edge_vld;
  logic [PHASE_W-1:0]    edge_pos;

  logic                  vld_p1;
  logic [NUM_PHASES-1:0] samples_p1;
  logic                  edge_vld_p1;
  logic [PHASE_W-1:0]    edge_pos_p1;
  phase_err_e            d_p1;

  logic                  skip;
  logic                  step_late;
  logic                  step_early;
  logic [PHASE_W-1:0]    phase_next;
  logic                  skip_next;
  logic [BITS_W-1:0]     bits_next;
  logic [NUM_BITS_W-1:0] num_bits_next;

  // Locate a single transition across the word, including the boundary
  // with the last sample of the previous word.
  always_comb begin
    w        = {in_samples, prev_sample};
    e        = w[NUM_PHASES-1:0] ^ w[NUM_PHASES:1];
    edge_vld = (e != '0) && ((e & (e - NUM_PHASES'(1))) == '0);
    edge_pos = '0;
    for (int k = 0; k < NUM_PHASES; k++)
      if (e[k]) edge_pos = PHASE_W'(k);
  end

  // ---- S1: edge info and samples ----
  // Control for stage 1 plus the inter-word sample history.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_p1      <= 1'b0;
      prev_sample <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) prev_sample <= in_samples[NUM_PHASES-1];
    end
  end

  // Stage 1 data capture.
  always_ff @(posedge aclk) begin
    if (in_valid) begin
      samples_p1  <= in_samples;
      edge_vld_p1 <= edge_vld;
      edge_pos_p1 <= edge_pos;
    end
  end

  assign d_p1 = phase_error(edge_pos_p1, phase);

  dru_phase_filter #(
    .FILT_THRESH (FILT_THRESH),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_filter (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .edge_valid (vld_p1 && edge_vld_p1),
    .d          (d_p1),
    .step_late  (step_late),
    .step_early (step_early),
    .locked     (locked)
  );

  // Select the recovered bit(s) with the pre-step phase and apply any step.
  // A late wrap 3->0 costs one bit on the next word; an early wrap 0->3
  // yields one extra bit now. A pending skip absorbs the whole word.
  always_comb begin
    phase_next    = phase;
    skip_next     = skip;
    bits_next     = '0;
    num_bits_next = '0;
    if (vld_p1) begin
      if (step_late)       phase_next = phase + PHASE_W'(1);
      else if (step_early) phase_next = phase - PHASE_W'(1);
      if (skip) begin
        skip_next = 1'b0;
      end else begin
        num_bits_next = NUM_BITS_W'(1);
        bits_next[0]  = samples_p1[phase];
        if (step_late && phase == PHASE_W'(NUM_PHASES - 1))
          skip_next = 1'b1;
        if (step_early && phase == '0) begin
          num_bits_next = NUM_BITS_W'(2);
          bits_next[1]  = samples_p1[0];
          bits_next[0]  = samples_p1[NUM_PHASES-1];
        end
      end
    end
  end

  // ---- S2: recovered bits and phase state ----
  // Output register and phase/skip state update.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase    <= PHASE_W'(INIT_PHASE);
      skip     <= 1'b0;
      bits     <= '0;
      num_bits <= '0;
    end else begin
      phase    <= phase_next;
      skip     <= skip_next;
      bits     <= bits_next;
      num_bits <= num_bits_next;
    end
  end

endmodule

// File: tb/tb_oversample_bit_recovery.sv
// Scoreboard bench for oversample_bit_recovery: directed tracking scenarios,
// randomized words, mid-stream reset and drifting Manchester frames.
module tb_oversample_bit_recovery;

  localparam int FT = 4;
  localparam int LC = 16;
  localparam int IP = 2;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [3:0] in_samples = 4'h0;
  logic       in_valid = 1'b0;
  logic [2:0] bits;
  logic [1:0] num_bits;
  logic       locked;
  logic [1:0] phase;

  always #5 aclk = ~aclk;

  oversample_bit_recovery #(
    .FILT_THRESH (FT),
    .LOCK_COUNT  (LC),
    .INIT_PHASE  (IP)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_samples (in_samples),
    .in_valid   (in_valid),
    .bits       (bits),
    .num_bits   (num_bits),
    .locked     (locked),
    .phase      (phase)
  );

  typedef struct packed {
    logic [2:0] bits;
    logic [1:0] nb;
    logic [1:0] phase;
    logic       locked;
  } exp_t;

  exp_t exp_q[$];
  bit   chip_q[$];
  bit   cap_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  // reference model state (integers, per-word rules)
  int m_phase, m_integ, m_lock;
  bit m_skip, m_prev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_phase = IP; m_integ = 0; m_lock = 0; m_skip = 0; m_prev = 0;
  endtask

  task automatic model_word(input logic [3:0] w);
    logic [4:0] s;
    int n_edges, k, d;
    bit late, early;
    exp_t ex;
    s = {w, m_prev};
    n_edges = 0; k = 0;
    for (int i = 0; i < 4; i++)
      if (s[i] != s[i+1]) begin n_edges++; k = i; end
    d = -1;
    if (n_edges == 1) d = (k + 2 - m_phase + 4) % 4;
    late = 0; early = 0;
    if (d == 1) begin
      m_integ++;
      if (m_integ >= FT) begin late = 1; m_integ = 0; end
    end else if (d == 3) begin
      m_integ--;
      if (m_integ <= -FT) begin early = 1; m_integ = 0; end
    end
    ex = '0;
    if (m_skip) begin
      m_skip = 0;
    end else if (early && m_phase == 0) begin
      ex.nb = 2'd2; ex.bits = {1'b0, w[0], w[3]};
    end else begin
      ex.nb = 2'd1; ex.bits = {2'b00, w[m_phase]};
      if (late && m_phase == 3) m_skip = 1;
    end
    if (late)  m_phase = (m_phase + 1) % 4;
    if (early) m_phase = (m_phase + 3) % 4;
    if (late || early || d == 2) m_lock = 0;
    else if (d == 0 && m_lock < LC) m_lock++;
    m_prev = w[3];
    ex.phase  = 2'(m_phase);
    ex.locked = (m_lock == LC);
    exp_q.push_back(ex);
  endtask

  function automatic logic [3:0] edge_word(input int k, input bit p);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = (j < k) ? p : ~p;
    return r;
  endfunction

  task automatic drive(input logic [3:0] w, input bit v);
    @(posedge aclk); #1;
    in_samples = w;
    in_valid   = v;
    if (v) model_word(w);
  endtask

  task automatic drain();
    repeat (3) drive(4'h0, 1'b0);
  endtask

  task automatic check_state(input string name, input int ph, input bit lk);
    @(negedge aclk);
    check({name, "_phase"}, 32'(phase), 32'(ph));
    check({name, "_locked"}, 32'(locked), 32'(lk));
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn  = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    model_reset();
  endtask

  task automatic run_manchester(input int drift, input string name);
    logic [7:0] frame[$];
    logic [7:0] payload[8];
    bit         chips[$];
    bit         smp[$];
    logic [15:0] pre;
    logic [3:0] w;
    int found, pos;
    logic [8:0] got;
    pre = 16'hAAD5;
    for (int i = 0; i < 12; i++) frame.push_back(8'hAA);
    frame.push_back(8'hAA);
    frame.push_back(8'hD5);
    for (int i = 0; i < 8; i++) begin
      payload[i] = 8'($urandom);
      frame.push_back(payload[i]);
    end
    frame.push_back(8'hAA);
    frame.push_back(8'hAA);
    foreach (frame[i])
      for (int b = 7; b >= 0; b--) begin
        chips.push_back(frame[i][b]);
        chips.push_back(~frame[i][b]);
      end
    foreach (chips[ci])
      repeat (((ci % 64) == 63) ? 4 + drift : 4) smp.push_back(chips[ci]);
    while ((smp.size() % 4) != 0) smp.push_back(smp[smp.size()-1]);
    chip_q.delete();
    cap_en = 1'b1;
    for (int n = 0; n < smp.size() / 4; n++) begin
      for (int j = 0; j < 4; j++) w[j] = smp[4*n + j];
      if ($urandom_range(0, 7) == 0) drive(4'($urandom), 1'b0);
      drive(w, 1'b1);
    end
    drain();
    @(negedge aclk);
    cap_en = 1'b0;
    found = -1;
    for (int i = 0; i + 32 <= chip_q.size() && found < 0; i++) begin
      bit ok;
      ok = 1;
      for (int j = 0; j < 32; j++)
        if (chip_q[i+j] != ((j % 2 == 0) ? pre[15 - j/2] : ~pre[15 - j/2])) ok = 0;
      if (ok) found = i;
    end
    check({name, "_sync"}, 32'(found >= 0), 32'd1);
    if (found >= 0) begin
      pos = found + 32;
      for (int b = 0; b < 8; b++) begin
        got = '0;
        for (int i = 7; i >= 0; i--) begin
          if (pos + 1 >= chip_q.size() || chip_q[pos] == chip_q[pos+1]) got[8] = 1'b1;
          else got[i] = chip_q[pos];
          pos += 2;
        end
        check($sformatf("%s_byte%0d", name, b), 32'(got), 32'({1'b0, payload[b]}));
      end
    end
  endtask

  // monitor: pops one expectation per word two edges after it was accepted
  initial begin
    bit   hist;
    bit   rst_now;
    bit   v_now;
    exp_t ex;
    hist = 0;
    forever begin
      @(posedge aclk);
      rst_now = !aresetn;
      v_now   = in_valid;
      @(negedge aclk);
      if (rst_now) begin
        check("reset_out", 32'({bits, num_bits, phase, locked}), 32'({3'b0, 2'b0, 2'(IP), 1'b0}));
        exp_q.delete();
        hist = 0;
      end else begin
        if (hist) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL underflow: output word with no expectation, num_bits %0d", num_bits);
          end else begin
            ex = exp_q.pop_front();
            check("word", 32'({bits, num_bits, phase, locked}), 32'(ex));
          end
          if (cap_en)
            for (int j = int'(num_bits) - 1; j >= 0; j--) chip_q.push_back(bits[j]);
        end else begin
          check("gap_num_bits", 32'(num_bits), 32'd0);
        end
        hist = v_now;
      end
    end
  end

  initial begin
    int tk;
    int r;
    logic [3:0] w;
    model_reset();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    check_state("reset", IP, 1'b0);

    // pull phase 2->1 with edges at 3, then 1->0 with edges at 2, then lock
    for (int i = 0; i < 8; i++)  drive(edge_word(3, m_prev), 1'b1);
    for (int i = 0; i < 24; i++) drive(edge_word(2, m_prev), 1'b1);
    drain();
    check_state("acquire", 0, 1'b1);

    // early edges at phase 0: double-bit word and wrap to phase 3
    for (int i = 0; i < 4; i++) drive(edge_word(1, m_prev), 1'b1);
    drain();
    check_state("early_wrap", 3, 1'b0);
    for (int i = 0; i < 20; i++) drive(edge_word(1, m_prev), 1'b1);
    drain();
    check_state("relock3", 3, 1'b1);

    // late edges at phase 3: wrap to 0, following word skipped
    for (int i = 0; i < 4; i++) drive(edge_word(2, m_prev), 1'b1);
    drain();
    check_state("late_wrap", 0, 1'b0);

    // constant input
    for (int i = 0; i < 100; i++) drive(4'hF, 1'b1);
    drain();
    check_state("const", 0, 1'b0);

    // glitches leave lock alone; a half-UI edge clears it
    for (int i = 0; i < 20; i++) drive(edge_word(2, m_prev), 1'b1);
    for (int i = 0; i < 3; i++)  drive(4'b0101, 1'b1);
    drain();
    check_state("glitch", 0, 1'b1);
    drive(edge_word(0, m_prev), 1'b1);
    drain();
    check_state("ambig", 0, 1'b0);

    // randomized words with gaps and a reset mid-stream
    tk = 2;
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) begin
        do_reset();
        check_state("mid_reset", IP, 1'b0);
      end
      if ($urandom_range(0, 5) == 0) drive(4'($urandom), 1'b0);
      r = $urandom_range(0, 99);
      if (r < 3) tk = (tk + ((r == 0) ? 3 : 1)) % 4;
      if (r < 70)      w = edge_word(tk, m_prev);
      else if (r < 85) w = {4{m_prev}};
      else             w = 4'($urandom);
      drive(w, 1'b1);
    end
    drain();

    // Manchester frames with slow and fast sample-clock drift
    do_reset();
    run_manchester(1, "manch_slow");
    do_reset();
    run_manchester(-1, "manch_fast");

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge aclk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
